// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types for the program-counter sequencing controller
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NEXT = 2'd0,
    OP_JUMP = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_EXEC = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

endpackage

// File: rtl/ret_stack.sv
// rtl/ret_stack.sv - return-address stack; pointer counts occupied entries
module ret_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] mem_d [2**AW];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [AW-1:0]    wr_idx, rd_idx;

  assign wr_idx = AW'(ptr_q);
  assign rd_idx = AW'(ptr_q - PW'(1));
  assign top    = mem_q[rd_idx];
  assign full   = (ptr_q == PW'(DEPTH));
  assign empty  = (ptr_q == '0);

  // The controller never asserts push on full or pop on empty.
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    if (clear) begin
      ptr_d = '0;
    end else if (push) begin
      mem_d[wr_idx] = push_data;
      ptr_d         = ptr_q + PW'(1);
    end else if (pop) begin
      ptr_d = ptr_q - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      mem_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - turns NEXT/JUMP/CALL/RET commands into single-cycle counter pulses
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [WIDTH-1:0] pc_in,
  output logic             pc_en,
  output logic             pc_load,
  output logic [WIDTH-1:0] pc_load_val,
  output logic             pc_oe,
  output logic             busy,
  output logic             stack_err
);

  state_e           state_q, state_d;
  logic             pc_en_q, pc_en_d;
  logic             pc_load_q, pc_load_d;
  logic [WIDTH-1:0] pc_load_val_q, pc_load_val_d;
  logic             pc_oe_q, pc_oe_d;
  logic             busy_q, busy_d;
  logic             stack_err_q, stack_err_d;

  logic             stk_push, stk_pop, stk_clear;
  logic             stk_full, stk_empty;
  logic [WIDTH-1:0] stk_top;

  ret_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (stk_push),
    .pop       (stk_pop),
    .clear     (stk_clear),
    .push_data (pc_in + WIDTH'(1)),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign cmd_ready = (state_q == ST_RUN) && !halt;

  always_comb begin
    state_d       = state_q;
    pc_en_d       = 1'b0;
    pc_load_d     = 1'b0;
    pc_load_val_d = '0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_clear     = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (halt) begin
          state_d = ST_IDLE;
        end else if (cmd_valid) begin
          state_d = ST_EXEC;
          case (cmd_op_e'(cmd_op))
            OP_NEXT: pc_en_d = 1'b1;
            OP_JUMP: begin
              pc_load_d     = 1'b1;
              pc_load_val_d = cmd_target;
            end
            OP_CALL: begin
              if (stk_full) begin
                state_d = ST_ERR;
              end else begin
                stk_push      = 1'b1;
                pc_load_d     = 1'b1;
                pc_load_val_d = cmd_target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                state_d = ST_ERR;
              end else begin
                stk_pop       = 1'b1;
                pc_load_d     = 1'b1;
                pc_load_val_d = stk_top;
              end
            end
            default: ;
          endcase
        end
      end
      ST_EXEC: state_d = halt ? ST_IDLE : ST_RUN;
      ST_ERR: begin
        if (start) begin
          stk_clear = 1'b1;
          state_d   = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered views of the state being entered.
    pc_oe_d     = (state_d == ST_RUN) || (state_d == ST_EXEC);
    busy_d      = pc_oe_d;
    stack_err_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_en_q       <= 1'b0;
      pc_load_q     <= 1'b0;
      pc_load_val_q <= '0;
      pc_oe_q       <= 1'b0;
      busy_q        <= 1'b0;
      stack_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_en_q       <= pc_en_d;
      pc_load_q     <= pc_load_d;
      pc_load_val_q <= pc_load_val_d;
      pc_oe_q       <= pc_oe_d;
      busy_q        <= busy_d;
      stack_err_q   <= stack_err_d;
    end
  end

  assign pc_en       = pc_en_q;
  assign pc_load     = pc_load_q;
  assign pc_load_val = pc_load_val_q;
  assign pc_oe       = pc_oe_q;
  assign busy        = busy_q;
  assign stack_err   = stack_err_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - directed plus random bench for pc_seq_ctrl with a queue-based stack model
module tb_pc_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             halt = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'd0;
  logic [WIDTH-1:0] cmd_target = '0;
  logic [WIDTH-1:0] pc_in = '0;
  logic             pc_en, pc_load, pc_oe, busy, stack_err;
  logic [WIDTH-1:0] pc_load_val;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] stk[$];
  bit in_err = 0;

  pc_seq_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt        (halt),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_target  (cmd_target),
    .pc_in       (pc_in),
    .pc_en       (pc_en),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc_oe       (pc_oe),
    .busy        (busy),
    .stack_err   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the emulated counter reacts to the pulses present before the edge.
  task automatic tick();
    logic en, ld;
    logic [WIDTH-1:0] v;
    en = pc_en; ld = pc_load; v = pc_load_val;
    @(posedge clk);
    #1;
    if (ld) pc_in = v;
    else if (en) pc_in = pc_in + 8'd1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 0);
    chk({tag, "_en"}, pc_en, 0);
    chk({tag, "_load"}, pc_load, 0);
    chk({tag, "_val"}, pc_load_val, 0);
    chk({tag, "_oe"}, pc_oe, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (in_err) stk.delete();
    in_err = 0;
    chk("start_ready", cmd_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_oe", pc_oe, 1);
    chk("start_err", stack_err, 0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] t, input bit halt_exec);
    logic e_en, e_ld, e_err;
    logic [WIDTH-1:0] e_val, pc0, e_pc;
    e_en = 0; e_ld = 0; e_err = 0; e_val = '0; pc0 = pc_in;
    case (op)
      2'd0: e_en = 1;
      2'd1: begin e_ld = 1; e_val = t; end
      2'd2: if (stk.size() >= DEPTH) e_err = 1;
            else begin stk.push_back(pc_in + 8'd1); e_ld = 1; e_val = t; end
      default: if (stk.size() == 0) e_err = 1;
               else begin e_val = stk.pop_back(); e_ld = 1; end
    endcase
    e_pc = e_err ? pc0 : (e_en ? pc0 + 8'd1 : e_val);
    chk("pre_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_target = t;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_target = 8'($urandom);
    chk("exec_en", pc_en, e_en);
    chk("exec_load", pc_load, e_ld);
    chk("exec_val", pc_load_val, e_val);
    chk("exec_ready", cmd_ready, 0);
    chk("exec_oe", pc_oe, !e_err);
    chk("exec_busy", busy, !e_err);
    chk("exec_serr", stack_err, e_err);
    if (e_err) begin
      in_err = 1;
      halt = 1'b1;
      tick();
      halt = 1'b0;
      chk("err_oe", pc_oe, 0);
      chk("err_ready", cmd_ready, 0);
      chk("err_sticky", stack_err, 1);
      chk("err_en", pc_en | pc_load, 0);
    end else begin
      halt = halt_exec;
      tick();
      halt = 1'b0;
      chk("post_pulse", {pc_en, pc_load}, 0);
      chk("post_val", pc_load_val, 0);
      chk("post_busy", busy, !halt_exec);
      chk("post_oe", pc_oe, !halt_exec);
      chk("post_ready", cmd_ready, !halt_exec);
    end
    chk("pc_in", pc_in, e_pc);
  endtask

  initial begin
    logic [WIDTH-1:0] pc_save;
    bit h;
    tick();
    chk_idle_outputs("rst");
    chk("rst_serr", stack_err, 0);
    rst_n = 1'b1;
    tick();
    chk_idle_outputs("idle");

    do_start();
    for (int i = 0; i < 3; i++) begin
      chk("next_pc_before", pc_in, i);
      issue(2'd0, 8'h00, 0);
    end
    issue(2'd1, 8'h40, 0);

    pc_in = 8'hFF;
    issue(2'd2, 8'h10, 0);
    issue(2'd3, 8'h00, 0);
    chk("stack_empty", stk.size(), 0);

    for (int i = 0; i < 5; i++) issue(2'd2, 8'(8'h20 + i), 0);
    chk("ovf_err", in_err, 1);
    do_start();
    issue(2'd3, 8'h00, 0);
    chk("unf_err", in_err, 1);
    do_start();

    // halt wins over a same-cycle command
    pc_save = pc_in;
    halt = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0;
    #1;
    chk("halt_ready", cmd_ready, 0);
    tick();
    halt = 1'b0; cmd_valid = 1'b0;
    chk("halt_busy", busy, 0);
    chk("halt_en", pc_en, 0);
    chk("halt_pc", pc_in, pc_save);
    do_start();
    pc_in = 8'h33;
    issue(2'd2, 8'h80, 0);
    issue(2'd1, 8'h90, 1);
    do_start();
    issue(2'd3, 8'h00, 0);
    chk("ret_saved", pc_in, 8'h34);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) pc_in = 8'($urandom);
      h = ($urandom_range(0, 7) == 0);
      issue(2'($urandom_range(0, 3)), 8'($urandom), h);
      if (in_err || h) do_start();
    end

    // asynchronous reset in the middle of a JUMP pulse
    pc_save = pc_in;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_target = 8'h5A;
    tick();
    cmd_valid = 1'b0;
    chk("mid_load", pc_load, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outputs("arst");
    chk("arst_serr", stack_err, 0);
    tick();
    chk("arst_pc", pc_in, pc_save);
    rst_n = 1'b1;
    stk.delete();
    in_err = 0;
    tick();
    do_start();
    issue(2'd3, 8'h00, 0);
    chk("arst_empty", in_err, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
